// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter types: default requester count, index type and EX_PACKET layout.
// The NUM_FU define sets the default requester count and may be overridden at build time.
`ifndef NUM_FU
`define NUM_FU 4
`endif

package cdb_arbiter_pkg;

  localparam int NUM_FU_DEF = `NUM_FU;
  localparam int FU_IDX_W   = $clog2(NUM_FU_DEF);

  typedef logic [FU_IDX_W-1:0] fu_idx_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] alu_result;
    logic [4:0]  dest_reg_idx;
    logic        take_branch;
    logic        rd_mem;
    logic        wr_mem;
    logic        halt;
    logic        illegal;
    logic        valid;
  } EX_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin pick: search req upward from ptr, wrapping, via double-width mask.
// No state or latency; gnt is one-hot (or zero when nothing requests), idx is its encoding.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    // Upper copy of req supplies the wrapped-around candidates below ptr.
    masked = dbl & ({(2*N){1'b1}} << ptr);
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (masked[i] && !any) begin
        any = 1'b1;
        idx = W'(i % N);
      end
    end
    for (int j = 0; j < N; j++) begin
      gnt[j] = any && (idx == W'(j));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one fu_grant per cycle, winner registered into ex_reg (1-cycle latency).
// Losers are back-pressured by fu_grant=0 and hold; CDB_ARB_BRANCH_PRIO_EN adds take_branch override.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_FU = `NUM_FU,
  localparam int IDX_W  = $clog2(NUM_FU)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [NUM_FU-1:0] fu_valid,
  input  EX_PACKET          fu_packet [NUM_FU],
  output logic [NUM_FU-1:0] fu_grant,
  output EX_PACKET          ex_reg,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_idx;
  logic [NUM_FU-1:0] rr_gnt;
  logic              rr_any;

  logic [IDX_W-1:0]  sel_idx;
  logic [NUM_FU-1:0] sel_gnt;
  logic              ptr_hold;
  logic              xfer;
  logic [IDX_W-1:0]  ptr_nxt;
  EX_PACKET          ex_nxt;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req (fu_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

`ifdef CDB_ARB_BRANCH_PRIO_EN
  logic [NUM_FU-1:0] br_req;
  logic [IDX_W-1:0]  br_idx;
  logic              br_override;

  always_comb begin
    br_req      = '0;
    br_idx      = '0;
    br_override = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      br_req[i] = fu_valid[i] && fu_packet[i].take_branch;
    end
    // Lowest-index branch resolver wins outright.
    for (int i = 0; i < NUM_FU; i++) begin
      if (br_req[i] && !br_override) begin
        br_override = 1'b1;
        br_idx      = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_idx  = rr_idx;
    sel_gnt  = rr_gnt;
    ptr_hold = 1'b0;
    if (br_override) begin
      sel_idx  = br_idx;
      sel_gnt  = '0;
      sel_gnt[br_idx] = 1'b1;
      // Override grants leave the round-robin order untouched.
      ptr_hold = 1'b1;
    end
  end
`else
  always_comb begin
    sel_idx  = rr_idx;
    sel_gnt  = rr_any ? rr_gnt : '0;
    ptr_hold = 1'b0;
  end
`endif

  always_comb begin
    fu_grant = (reset && !flush) ? sel_gnt : '0;
    xfer     = |fu_grant;
    ptr_nxt  = (sel_idx == IDX_W'(NUM_FU - 1)) ? '0 : sel_idx + 1'b1;
    ex_nxt   = fu_packet[sel_idx];
    ex_nxt.valid = fu_valid[sel_idx] & fu_packet[sel_idx].valid;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_reg    <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      ex_reg    <= ex_nxt;
      grant_idx <= sel_idx;
      if (!ptr_hold) begin
        rr_ptr <= ptr_nxt;
      end
    end else begin
      ex_reg.valid <= 1'b0;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clock) disable iff (!reset) $onehot0(fu_grant));
  a_flush_no_grant : assert property (@(posedge clock) disable iff (!reset) flush |-> (fu_grant == '0));
  a_grant_has_req : assert property (@(posedge clock) disable iff (!reset) (fu_grant & ~fu_valid) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU=4): vector table for arbitration/flush/wrap,
// plus hand sequences for reset, data path, async reset mid-transfer and fairness.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [3:0] fu_valid;
  EX_PACKET   fu_packet [4];
  logic [3:0] fu_grant;
  EX_PACKET   ex_reg;
  logic [1:0] grant_idx;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       flush;
    logic [3:0] vld;
    logic [3:0] br;
    logic [3:0] gnt;
    logic       ev;
    int         idx;
    int         ptr;
  } vec_t;

  vec_t tbl [21];

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_packet (fu_packet),
    .fu_grant  (fu_grant),
    .ex_reg    (ex_reg),
    .grant_idx (grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [3:0] vld, input logic [3:0] br);
    flush    = fl;
    fu_valid = vld;
    for (int i = 0; i < 4; i++) begin
      fu_packet[i]              = '0;
      fu_packet[i].npc          = 32'h0000_1000 + 32'(4 * i);
      fu_packet[i].alu_result   = 32'hA000_0000 + 32'(i);
      fu_packet[i].dest_reg_idx = 5'(i + 1);
      fu_packet[i].take_branch  = br[i];
      fu_packet[i].valid        = 1'b1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 0, 1};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1, 2};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2, 3};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b1, 3, 0};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 0, 1};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1, 2};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2, 3};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b1, 3, 0};
    tbl[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2, 3};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 3};
    tbl[10] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 0, 3};
    tbl[11] = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b1, 3, 0};
    tbl[12] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2, 3};
    tbl[13] = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1, 3, 0};
    tbl[14] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 1'b1, 0, 1};
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1};
    tbl[16] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 0, 1};
    tbl[17] = '{1'b0, 4'b0110, 4'b0000, 4'b0010, 1'b1, 1, 2};
    tbl[18] = '{1'b0, 4'b0110, 4'b0000, 4'b0100, 1'b1, 2, 3};
`ifdef CDB_ARB_BRANCH_PRIO_EN
    tbl[19] = '{1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1, 1, 3};
    tbl[20] = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b1, 0, 1};
`else
    tbl[19] = '{1'b0, 4'b0011, 4'b0010, 4'b0001, 1'b1, 0, 1};
    tbl[20] = '{1'b0, 4'b0011, 4'b0000, 4'b0010, 1'b1, 1, 2};
`endif

    // Held in reset with every requester valid.
    reset = 1'b0;
    drive(1'b0, 4'b1111, 4'b0000);
    @(negedge clock);
    chk("rst_grant", 32'(fu_grant), 32'h0);
    chk("rst_ex_valid", 32'(ex_reg.valid), 32'h0);
    chk("rst_grant_idx", 32'(grant_idx), 32'h0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int k = 0; k < 21; k++) begin
      drive(tbl[k].flush, tbl[k].vld, tbl[k].br);
      @(negedge clock);
      chk($sformatf("v%0d_grant", k), 32'(fu_grant), 32'(tbl[k].gnt));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_ex_valid", k), 32'(ex_reg.valid), 32'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk($sformatf("v%0d_grant_idx", k), 32'(grant_idx), 32'(tbl[k].idx));
        chk($sformatf("v%0d_alu", k), ex_reg.alu_result, 32'hA000_0000 + 32'(tbl[k].idx));
        chk($sformatf("v%0d_dest", k), 32'(ex_reg.dest_reg_idx), 32'(tbl[k].idx + 1));
      end
      chk($sformatf("v%0d_rr_ptr", k), 32'(dut.rr_ptr), 32'(tbl[k].ptr));
    end

    // Lone requester 2 carrying a distinctive result.
    drive(1'b0, 4'b0100, 4'b0000);
    fu_packet[2].alu_result = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("single_grant", 32'(fu_grant), 32'h4);
    @(posedge clock);
    #1;
    chk("single_ex_valid", 32'(ex_reg.valid), 32'h1);
    chk("single_alu", ex_reg.alu_result, 32'hDEAD_BEEF);
    chk("single_grant_idx", 32'(grant_idx), 32'h2);
    chk("single_rr_ptr", 32'(dut.rr_ptr), 32'h3);
    drive(1'b0, 4'b0000, 4'b0000);
    @(posedge clock);
    #1;
    chk("single_idle_valid", 32'(ex_reg.valid), 32'h0);

    // Reset asserted while a result sits in ex_reg: cleared without a clock edge.
    drive(1'b0, 4'b1111, 4'b0000);
    @(posedge clock);
    #1;
    chk("midrst_pre_valid", 32'(ex_reg.valid), 32'h1);
    chk("midrst_pre_idx", 32'(grant_idx), 32'h3);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ex_valid", 32'(ex_reg.valid), 32'h0);
    chk("midrst_grant_idx", 32'(grant_idx), 32'h0);
    chk("midrst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    chk("midrst_grant", 32'(fu_grant), 32'h0);
    reset = 1'b1;

    // Fairness after reset release: every held requester served in rotation.
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("fair%0d_grant", k), 32'(fu_grant), 32'h1 << k);
      @(posedge clock);
      #1;
      chk($sformatf("fair%0d_grant_idx", k), 32'(grant_idx), 32'(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
